// File: rtl/rf_8x16.sv
// Eight-entry x 16-bit register file: two combinational read ports, one write port.
// Latency: reads 0 cycles, writes visible from the cycle after the committing edge.
// Backpressure: none; every write with write=1 commits on the next rising clk edge.
//
// Ports:
//   clk, rst                 : clock; synchronous active-high reset clears R0-R7
//   read1regsel/read2regsel  : read port selects -> read1data/read2data
//   writeregsel/writedata    : write port index and data, committed when write=1
//   err                      : 1 when any select/write (or writedata while writing) is X/Z
// Optional feature macro: RF_BYPASS_EN (forward writedata to a read port selecting
// the register being written in the same cycle).

// 16-bit write-enabled register stage; one instance per file entry.
module rf_reg16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  logic [15:0] data_q;
  logic [15:0] data_d;

  always_comb begin
    data_d = data_q;
    if (we_i) data_d = d_i;
  end

  // rst dominates any write arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst) data_q <= 16'h0000;
    else     data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

module rf_8x16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  read1regsel,
  input  logic [2:0]  read2regsel,
  input  logic [2:0]  writeregsel,
  input  logic [15:0] writedata,
  input  logic        write,
  output logic [15:0] read1data,
  output logic [15:0] read2data,
  output logic        err
);

  logic [7:0]  reg_we;
  logic [15:0] reg_q [8];
  logic [15:0] rd1_stored;
  logic [15:0] rd2_stored;

  // One-hot write decode: no enable at all when write=0.
  always_comb begin
    reg_we = 8'h00;
    for (int i = 0; i < 8; i++) begin
      reg_we[i] = write && (writeregsel == 3'(i));
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_reg
    rf_reg16 u_reg (
      .clk  (clk),
      .rst  (rst),
      .we_i (reg_we[g]),
      .d_i  (writedata),
      .q_o  (reg_q[g])
    );
  end

  assign rd1_stored = reg_q[read1regsel];
  assign rd2_stored = reg_q[read2regsel];

`ifdef RF_BYPASS_EN
  // Forward only when the write will actually commit (rst would discard it).
  logic byp_wr;
  assign byp_wr    = write && !rst;
  assign read1data = (byp_wr && (read1regsel == writeregsel)) ? writedata : rd1_stored;
  assign read2data = (byp_wr && (read2regsel == writeregsel)) ? writedata : rd2_stored;
`else
  assign read1data = rd1_stored;
  assign read2data = rd2_stored;
`endif

  // Simulation-visible unknown detection; resolves to 0 in 2-state hardware.
  // writedata is only inspected while a write is requested.
  always_comb begin
    err = 1'b0;
    if ($isunknown({write, writeregsel, read1regsel, read2regsel})) err = 1'b1;
    else if (write && $isunknown(writedata))                        err = 1'b1;
  end

endmodule
